// File: rtl/ped_pkg.sv
// Shared types for the pedestrian crossing: controller states, the four legal
// upstream lamp codes ({red,amber,green}) and a legality helper.
package ped_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITING,
    ST_WALK,
    ST_FLASH,
    ST_FAULT
  } ped_state_e;

  localparam logic [2:0] LAMP_R  = 3'b100;
  localparam logic [2:0] LAMP_RA = 3'b110;
  localparam logic [2:0] LAMP_G  = 3'b001;
  localparam logic [2:0] LAMP_A  = 3'b010;

  function automatic logic lamp_legal(input logic [2:0] code);
    return (code == LAMP_R) || (code == LAMP_RA) || (code == LAMP_G) || (code == LAMP_A);
  endfunction

endpackage

// File: rtl/ped_cycle_counter.sv
// Loadable 8-bit down-counter; done flags the last clock of a loaded interval
// (count of 1), so an interval loaded with N lasts exactly N clocks.
module ped_cycle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  output logic       done_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 8'd1);

endmodule

// File: rtl/pedestrian_crossing.sv
// Pedestrian crossing controller slaved to an upstream traffic-light block.
// Define PED_COUNTDOWN_EN to drive the remaining walk+flash countdown output.
module pedestrian_crossing
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int FLASH_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       red,
  input  logic       amber,
  input  logic       green,
  input  logic       button,
  output logic       walk,
  output logic       dont_walk,
  output logic       wait_lamp,
  output logic       req_ack,
  output logic       conflict,
  output logic       fault,
  output logic [7:0] countdown
);

  localparam logic [7:0] WALK_LD  = 8'(WALK_CYCLES);
  localparam logic [7:0] FLASH_LD = 8'(FLASH_CYCLES);
  localparam logic [6:0] HALF_PER = 7'(FLASH_PERIOD);

  ped_state_e state_q, state_d;
  logic [2:0] lamps;
  logic       walk_q, walk_d, dw_q, dw_d, wait_q, wait_d;
  logic       ack_q, ack_d, conf_q, conf_d, fault_q, fault_d;
  logic [6:0] ph_q, ph_d;
  logic       cnt_load, cnt_en, cnt_done;
  logic [7:0] cnt_val;

  assign lamps = {red, amber, green};

  ped_cycle_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .done_o     (cnt_done)
  );

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    state_d  = state_q;
    walk_d   = 1'b0;
    dw_d     = 1'b1;
    wait_d   = 1'b0;
    ack_d    = 1'b0;
    conf_d   = 1'b0;
    fault_d  = 1'b0;
    ph_d     = ph_q;
    cnt_load = 1'b0;
    cnt_val  = 8'd0;
    cnt_en   = 1'b0;
    if ((state_q == ST_FAULT) || !lamp_legal(lamps)) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (button) begin
            state_d = ST_WAITING;
            ack_d   = 1'b1;
            wait_d  = 1'b1;
          end
        end
        ST_WAITING: begin
          wait_d = 1'b1;
          if (lamps == LAMP_R) begin
            state_d  = ST_WALK;
            wait_d   = 1'b0;
            walk_d   = 1'b1;
            dw_d     = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = WALK_LD;
          end
        end
        ST_WALK, ST_FLASH: begin
          if (!red) begin
            // Traffic lost red mid-crossing: abort but keep the request.
            state_d = ST_WAITING;
            wait_d  = 1'b1;
            conf_d  = 1'b1;
          end else if (cnt_done) begin
            if (state_q == ST_WALK) begin
              state_d  = ST_FLASH;
              cnt_load = 1'b1;
              cnt_val  = FLASH_LD;
              ph_d     = 7'd1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_en = 1'b1;
            if (state_q == ST_WALK) begin
              walk_d = 1'b1;
              dw_d   = 1'b0;
            end else if (ph_q == HALF_PER) begin
              dw_d = ~dw_q;
              ph_d = 7'd1;
            end else begin
              dw_d = dw_q;
              ph_d = ph_q + 7'd1;
            end
          end
        end
        default: begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
      wait_q  <= 1'b0;
      ack_q   <= 1'b0;
      conf_q  <= 1'b0;
      fault_q <= 1'b0;
      ph_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      conf_q  <= conf_d;
      fault_q <= fault_d;
      ph_q    <= ph_d;
    end
  end

`ifdef PED_COUNTDOWN_EN
  localparam logic [7:0] TOTAL_LD = 8'(WALK_CYCLES + FLASH_CYCLES);
  logic [7:0] cd_q, cd_d;

  always_comb begin
    cd_d = 8'd0;
    if ((state_q == ST_WAITING) && (state_d == ST_WALK)) begin
      cd_d = TOTAL_LD;
    end else if ((state_d == ST_WALK) || (state_d == ST_FLASH)) begin
      cd_d = cd_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cd_q <= 8'd0;
    end else begin
      cd_q <= cd_d;
    end
  end

  assign countdown = cd_q;
`else
  assign countdown = 8'd0;
`endif

  assign walk      = walk_q;
  assign dont_walk = dw_q;
  assign wait_lamp = wait_q;
  assign req_ack   = ack_q;
  assign conflict  = conf_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_pedestrian_crossing.sv
// Randomised and directed bench for pedestrian_crossing against a timeline model.
module tb_pedestrian_crossing;

  localparam int W = 4;
  localparam int F = 4;
  localparam int P = 2;

  localparam bit [2:0] C_R  = 3'b100;
  localparam bit [2:0] C_RA = 3'b110;
  localparam bit [2:0] C_G  = 3'b001;
  localparam bit [2:0] C_A  = 3'b010;

  logic       clk, rst_n, red, amber, green, button;
  logic       walk, dont_walk, wait_lamp, req_ack, conflict, fault;
  logic [7:0] countdown;

  int n_pass = 0;
  int n_tot  = 0;

  // Model: mode 0=idle 1=request pending 2=crossing 3=fault; t = clocks since crossing began
  int m_mode = 0;
  int m_t    = 0;
  bit m_ack  = 0;
  bit m_conf = 0;

  pedestrian_crossing #(
    .WALK_CYCLES  (W),
    .FLASH_CYCLES (F),
    .FLASH_PERIOD (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .red       (red),
    .amber     (amber),
    .green     (green),
    .button    (button),
    .walk      (walk),
    .dont_walk (dont_walk),
    .wait_lamp (wait_lamp),
    .req_ack   (req_ack),
    .conflict  (conflict),
    .fault     (fault),
    .countdown (countdown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_step(input bit rn, input bit [2:0] code, input bit btn);
    bit legal;
    legal  = (code == C_R) || (code == C_RA) || (code == C_G) || (code == C_A);
    m_ack  = 0;
    m_conf = 0;
    if (!rn) begin
      m_mode = 0;
      m_t    = 0;
    end else if (m_mode == 3 || !legal) begin
      m_mode = 3;
    end else if (m_mode == 0) begin
      if (btn) begin
        m_mode = 1;
        m_ack  = 1;
      end
    end else if (m_mode == 1) begin
      if (code == C_R) begin
        m_mode = 2;
        m_t    = 0;
      end
    end else begin
      if (!code[2]) begin
        m_mode = 1;
        m_conf = 1;
      end else begin
        m_t = m_t + 1;
        if (m_t == W + F) m_mode = 0;
      end
    end
  endfunction

  function automatic int exp_walk();
    return (m_mode == 2 && m_t < W) ? 1 : 0;
  endfunction

  function automatic int exp_dw();
    if (m_mode != 2) return 1;
    if (m_t < W) return 0;
    return (((m_t - W) / P) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int exp_cd();
`ifdef PED_COUNTDOWN_EN
    return (m_mode == 2) ? (W + F - m_t) : 0;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input bit rn, input bit [2:0] code, input bit btn);
    rst_n = rn;
    {red, amber, green} = code;
    button = btn;
    @(posedge clk);
    model_step(rn, code, btn);
    #1;
    check("walk",      int'(walk),      exp_walk());
    check("dont_walk", int'(dont_walk), exp_dw());
    check("wait_lamp", int'(wait_lamp), (m_mode == 1) ? 1 : 0);
    check("req_ack",   int'(req_ack),   int'(m_ack));
    check("conflict",  int'(conflict),  int'(m_conf));
    check("fault",     int'(fault),     (m_mode == 3) ? 1 : 0);
    check("countdown", int'(countdown), exp_cd());
  endtask

  initial begin
    int acks;
    int x;
    bit [2:0] code;
    rst_n = 1'b0; red = 1'b0; amber = 1'b0; green = 1'b1; button = 1'b0;

    step(0, C_G, 0);
    step(0, C_G, 0);
    check("rst_dw", int'(dont_walk), 1);
    check("rst_walk", int'(walk), 0);
    check("rst_cd", int'(countdown), 0);

    // Request on green
    step(1, C_G, 1);
    check("r031_ack", int'(req_ack), 1);
    check("r031_wait", int'(wait_lamp), 1);
    step(1, C_G, 0);
    check("r031_ack_off", int'(req_ack), 0);
    check("r031_dw", int'(dont_walk), 1);

    // Full walk and flash on held red
    for (int i = 0; i < W; i++) begin
      step(1, C_R, 0);
      check("r032_walk", int'(walk), 1);
`ifdef PED_COUNTDOWN_EN
      check("r032_cd", int'(countdown), 8 - i);
`endif
    end
    step(1, C_R, 0); check("r032_f0", int'(dont_walk), 1);
    step(1, C_R, 0); check("r032_f1", int'(dont_walk), 1);
    step(1, C_R, 0); check("r032_f2", int'(dont_walk), 0);
    step(1, C_R, 0); check("r032_f3", int'(dont_walk), 0);
    check("r032_f3_walk", int'(walk), 0);
    step(1, C_R, 0);
    check("r032_idle_dw", int'(dont_walk), 1);
    check("r032_idle_wait", int'(wait_lamp), 0);

    // Abort in the second walk clock
    step(1, C_G, 1);
    step(1, C_R, 0);
    step(1, C_R, 0);
    step(1, C_G, 0);
    check("r033_conflict", int'(conflict), 1);
    check("r033_walk", int'(walk), 0);
    check("r033_wait", int'(wait_lamp), 1);
    step(1, C_R, 0);
    check("r033_rewalk", int'(walk), 1);
    check("r033_conf_off", int'(conflict), 0);
    for (int i = 0; i < W + F; i++) step(1, C_R, 0);

    // Reset during flash
    step(1, C_G, 1);
    for (int i = 0; i < W + 1; i++) step(1, C_R, 0);
    step(0, C_R, 0);
    check("r035_dw", int'(dont_walk), 1);
    check("r035_walk", int'(walk), 0);
    check("r035_cd", int'(countdown), 0);

    // Held button: one ack per request cycle
    acks = 0;
    for (int i = 0; i < 11; i++) begin
      step(1, C_R, 1);
      acks += int'(req_ack);
    end
    check("r036_acks", acks, 2);

    // Illegal R+G is sticky
    step(1, 3'b101, 1);
    check("r034_fault", int'(fault), 1);
    check("r034_dw", int'(dont_walk), 1);
    step(1, C_G, 1);
    step(1, C_R, 1);
    check("r034_sticky", int'(fault), 1);
    check("r034_no_ack", int'(req_ack), 0);
    step(0, C_G, 0);
    check("r034_cleared", int'(fault), 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      x = int'($urandom_range(0, 99));
      if (x < 2)       code = 3'($urandom_range(0, 7));
      else if (x < 72) code = C_R;
      else if (x < 78) code = C_RA;
      else if (x < 90) code = C_G;
      else             code = C_A;
      step(($urandom_range(0, 59) != 0), code, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
